word_queue: RTL and testbench
=============================

WORD_QUEUE -- requirements
Module: word_queue

Interface
REQ-001 Parameter WORD_RANGE, default 8, data word width in bits.
REQ-002 Parameter WORD_COUNT, default 64, queue depth in words; power of two, >= 2.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 RstN  input  1  reset, synchronous, active-high (name retained per codebase convention; asserted = 1).
REQ-005 Enable  input  1  when 0, Push/Pop ignored and all state held.
REQ-006 Push  input  1  enqueue request; Data_in written at tail.
REQ-007 Pop  input  1  dequeue request; head word returned on Data_out.
REQ-008 Data_in  input  WORD_RANGE  word to enqueue.
REQ-009 Data_out  output  WORD_RANGE  registered dequeued word.
REQ-010 Valid_out  output  1  high for exactly one cycle after an accepted pop.
REQ-011 Full  output  1  registered; 1 when Count == WORD_COUNT.
REQ-012 Empty  output  1  registered; 1 when Count == 0.
REQ-013 Count  output  $clog2(WORD_COUNT)+1  number of stored words.

Function
REQ-014 Storage SHALL be a circular buffer indexed by head and tail pointers of $clog2(WORD_COUNT) bits, wrapping WORD_COUNT-1 -> 0.
REQ-015 Order SHALL be first-in first-out: words leave in enqueue order.
REQ-016 Pop accepted iff Enable & Pop & ~Empty; head word latched to Data_out, Valid_out = 1 at that edge, head advances.
REQ-017 Push accepted iff Enable & Push & (~Full | pop accepted this cycle); Data_in written at tail, tail advances.
REQ-018 Push and pop both accepted: Count unchanged; at Full both accepted and Full stays 1.
REQ-019 Push and pop while Empty: pop rejected, push accepted, Valid_out = 0; no same-cycle bypass.
REQ-020 Rejected push/pop SHALL alter no state; Valid_out = 0 that cycle.
REQ-021 Data_out SHALL hold its last value when no pop is accepted.
REQ-022 Full, Empty, Count SHALL reflect state after the edge (one-cycle latency from request to flag update).

Reset
REQ-023 RstN = 1 at a rising edge: head = tail = 0, Count = 0, Empty = 1, Full = 0, Valid_out = 0, Data_out = 0.
REQ-024 Reset SHALL take priority over Enable/Push/Pop in the same cycle; stored contents need not be cleared.
REQ-025 Reset mid-operation SHALL discard all queued words; first pop after reset with no push SHALL be rejected.

Configuration
REQ-026 Macro WORD_QUEUE_ERROR_FLAGS_EN SHALL add outputs Overflow and Underflow (1 bit each).
REQ-027 With macro: Overflow sets sticky on Enable & Push rejected due to Full; Underflow sets sticky on Enable & Pop while Empty; both cleared only by reset.
REQ-028 Without macro: ports absent, no extra logic; all other behaviour identical.

Verification (WORD_RANGE=8, WORD_COUNT=4)
REQ-029 Reset, push 0x11,0x22,0x33 -> Count=3; pop x3 -> Data_out 0x11,0x22,0x33 each with one-cycle Valid_out; Empty=1.
REQ-030 Push 0xA0..0xA3 -> Full=1, Count=4; push 0xFF -> rejected, Count=4; pop x4 returns 0xA0..0xA3 (Overflow=1 with macro).
REQ-031 Pointer wrap: push 3, pop 3, push 0x51..0x54, pop 4 -> 0x51..0x54 in order, Empty=1.
REQ-032 At Full, Push=Pop=1 with Data_in=0x77 -> Data_out=oldest word, Count=4, 0x77 dequeued fourth afterwards.
REQ-033 Empty, Push=Pop=1, Data_in=0x42 -> Valid_out=0, Count=1; next pop -> 0x42 (Underflow stays 0 with macro).
REQ-034 Enable=0 with Push/Pop toggling -> no change; RstN=1 with Count=3 -> Count=0, Empty=1 next cycle; pop rejected.

Source files
------------

// File: rtl/word_queue.sv
// Circular-buffer FIFO with registered dequeue data and registered Full/Empty/Count.
// Optional sticky Overflow/Underflow outputs are enabled by defining WORD_QUEUE_ERROR_FLAGS_EN.
module word_queue #(
  parameter int WORD_RANGE = 8,
  parameter int WORD_COUNT = 64
) (
  input  logic                          Clk,
  input  logic                          RstN,
  input  logic                          Enable,
  input  logic                          Push,
  input  logic                          Pop,
  input  logic [WORD_RANGE-1:0]         Data_in,
  output logic [WORD_RANGE-1:0]         Data_out,
  output logic                          Valid_out,
  output logic                          Full,
  output logic                          Empty,
`ifdef WORD_QUEUE_ERROR_FLAGS_EN
  output logic [$clog2(WORD_COUNT):0]   Count,
  output logic                          Overflow,
  output logic                          Underflow
`else
  output logic [$clog2(WORD_COUNT):0]   Count
`endif
);

  localparam int PW = $clog2(WORD_COUNT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(WORD_COUNT);

  logic [WORD_RANGE-1:0] mem [WORD_COUNT];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  pop_ok;
  logic                  push_ok;
  logic [CW-1:0]         count_next;

  // A full queue can still take a push when a pop frees the head slot on the same edge.
  always_comb begin
    pop_ok     = Enable & Pop & ~Empty;
    push_ok    = Enable & Push & (~Full | pop_ok);
    count_next = Count;
    if (push_ok && !pop_ok)
      count_next = Count + CW'(1);
    else if (pop_ok && !push_ok)
      count_next = Count - CW'(1);
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge Clk) begin
    if (push_ok)
      mem[tail] <= Data_in;
  end

  always_ff @(posedge Clk) begin
    if (RstN) begin
      head      <= '0;
      tail      <= '0;
      Count     <= '0;
      Empty     <= 1'b1;
      Full      <= 1'b0;
      Valid_out <= 1'b0;
      Data_out  <= '0;
    end else begin
      Valid_out <= pop_ok;
      if (pop_ok) begin
        Data_out <= mem[head];
        head     <= head + PW'(1);
      end
      if (push_ok)
        tail <= tail + PW'(1);
      Count <= count_next;
      Empty <= (count_next == '0);
      Full  <= (count_next == COUNT_MAX);
    end
  end

`ifdef WORD_QUEUE_ERROR_FLAGS_EN
  // A simultaneous push into an empty queue is a legal handoff, not an underflow.
  always_ff @(posedge Clk) begin
    if (RstN) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (Enable && Push && !push_ok)
        Overflow <= 1'b1;
      if (Enable && Pop && Empty && !Push)
        Underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_word_queue.sv
// Directed self-checking bench for word_queue (WORD_RANGE=8, WORD_COUNT=4).
// Define WORD_QUEUE_ERROR_FLAGS_EN for both files to also check Overflow/Underflow.
module tb_word_queue;

  logic       Clk = 1'b0;
  logic       RstN = 1'b1;
  logic       Enable = 1'b0;
  logic       Push = 1'b0;
  logic       Pop = 1'b0;
  logic [7:0] Data_in = 8'h00;
  logic [7:0] Data_out;
  logic       Valid_out;
  logic       Full;
  logic       Empty;
  logic [2:0] Count;
`ifdef WORD_QUEUE_ERROR_FLAGS_EN
  logic       Overflow;
  logic       Underflow;
`endif

  int checks = 0;
  int errors = 0;

  word_queue #(.WORD_RANGE(8), .WORD_COUNT(4)) dut (
    .Clk(Clk), .RstN(RstN), .Enable(Enable), .Push(Push), .Pop(Pop),
    .Data_in(Data_in), .Data_out(Data_out), .Valid_out(Valid_out),
    .Full(Full), .Empty(Empty),
`ifdef WORD_QUEUE_ERROR_FLAGS_EN
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
`else
    .Count(Count)
`endif
  );

  always #5 Clk = ~Clk;

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic en, input logic pu, input logic po, input logic [7:0] din);
    Enable = en; Push = pu; Pop = po; Data_in = din;
    @(posedge Clk);
    #1;
    Enable = 1'b0; Push = 1'b0; Pop = 1'b0;
  endtask

  task automatic test_reset();
    RstN = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    RstN = 1'b0;
    checks++;
    if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", Count); end
    checks++;
    if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL reset_flags got E=%b F=%b exp E=1 F=0", Empty, Full); end
    checks++;
    if (Valid_out !== 1'b0 || Data_out !== 8'h00) begin errors++; $display("FAIL reset_out got V=%b D=%h exp V=0 D=00", Valid_out, Data_out); end
  endtask

  task automatic test_basic_fifo();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, exp[i]);
    checks++;
    if (Count !== 3'd3 || Empty !== 1'b0) begin errors++; $display("FAIL basic_fill got C=%0d E=%b exp C=3 E=0", Count, Empty); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (Valid_out !== 1'b1 || Data_out !== exp[i]) begin errors++; $display("FAIL basic_pop%0d got V=%b D=%h exp V=1 D=%h", i, Valid_out, Data_out, exp[i]); end
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (Valid_out !== 1'b0 || Data_out !== 8'h33) begin errors++; $display("FAIL basic_hold got V=%b D=%h exp V=0 D=33", Valid_out, Data_out); end
    checks++;
    if (Empty !== 1'b1 || Count !== 3'd0) begin errors++; $display("FAIL basic_empty got E=%b C=%0d exp E=1 C=0", Empty, Count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i));
    checks++;
    if (Full !== 1'b1 || Count !== 3'd4) begin errors++; $display("FAIL full_set got F=%b C=%0d exp F=1 C=4", Full, Count); end
    step(1'b1, 1'b1, 1'b0, 8'hFF);
    checks++;
    if (Full !== 1'b1 || Count !== 3'd4 || Valid_out !== 1'b0) begin errors++; $display("FAIL full_reject got F=%b C=%0d V=%b exp F=1 C=4 V=0", Full, Count, Valid_out); end
`ifdef WORD_QUEUE_ERROR_FLAGS_EN
    checks++;
    if (Overflow !== 1'b1 || Underflow !== 1'b0) begin errors++; $display("FAIL full_overflow got O=%b U=%b exp O=1 U=0", Overflow, Underflow); end
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (Valid_out !== 1'b1 || Data_out !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL full_pop%0d got V=%b D=%h exp V=1 D=%h", i, Valid_out, Data_out, 8'hA0 + 8'(i)); end
    end
    checks++;
    if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL full_drained got E=%b F=%b exp E=1 F=0", Empty, Full); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h01 + 8'(i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (Data_out !== 8'h03 || Empty !== 1'b1) begin errors++; $display("FAIL wrap_pre got D=%h E=%b exp D=03 E=1", Data_out, Empty); end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h51 + 8'(i));
    checks++;
    if (Full !== 1'b1) begin errors++; $display("FAIL wrap_full got F=%b exp F=1", Full); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (Valid_out !== 1'b1 || Data_out !== 8'h51 + 8'(i)) begin errors++; $display("FAIL wrap_pop%0d got V=%b D=%h exp V=1 D=%h", i, Valid_out, Data_out, 8'h51 + 8'(i)); end
    end
    checks++;
    if (Empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got E=%b exp E=1", Empty); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4];
    exp[0] = 8'hB1; exp[1] = 8'hB2; exp[2] = 8'hB3; exp[3] = 8'h77;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'hB0 + 8'(i));
    step(1'b1, 1'b1, 1'b1, 8'h77);
    checks++;
    if (Valid_out !== 1'b1 || Data_out !== 8'hB0) begin errors++; $display("FAIL fpp_out got V=%b D=%h exp V=1 D=b0", Valid_out, Data_out); end
    checks++;
    if (Count !== 3'd4 || Full !== 1'b1) begin errors++; $display("FAIL fpp_count got C=%0d F=%b exp C=4 F=1", Count, Full); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (Data_out !== exp[i]) begin errors++; $display("FAIL fpp_pop%0d got D=%h exp D=%h", i, Data_out, exp[i]); end
    end
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 1'b1, 1'b1, 8'h42);
    checks++;
    if (Valid_out !== 1'b0 || Count !== 3'd1 || Empty !== 1'b0) begin errors++; $display("FAIL epp_state got V=%b C=%0d E=%b exp V=0 C=1 E=0", Valid_out, Count, Empty); end
`ifdef WORD_QUEUE_ERROR_FLAGS_EN
    checks++;
    if (Underflow !== 1'b0) begin errors++; $display("FAIL epp_underflow got U=%b exp U=0", Underflow); end
`endif
    step(1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (Valid_out !== 1'b1 || Data_out !== 8'h42) begin errors++; $display("FAIL epp_pop got V=%b D=%h exp V=1 D=42", Valid_out, Data_out); end
  endtask

  task automatic test_enable_and_midreset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h61 + 8'(i));
    for (int i = 0; i < 6; i++) step(1'b0, i[0], ~i[0], 8'hC0 + 8'(i));
    checks++;
    if (Count !== 3'd3 || Valid_out !== 1'b0 || Data_out !== 8'h42) begin errors++; $display("FAIL en_hold got C=%0d V=%b D=%h exp C=3 V=0 D=42", Count, Valid_out, Data_out); end
    RstN = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'h99);
    RstN = 1'b0;
    checks++;
    if (Count !== 3'd0 || Empty !== 1'b1 || Valid_out !== 1'b0) begin errors++; $display("FAIL midreset got C=%0d E=%b V=%b exp C=0 E=1 V=0", Count, Empty, Valid_out); end
`ifdef WORD_QUEUE_ERROR_FLAGS_EN
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL midreset_ovf got O=%b exp O=0", Overflow); end
`endif
    step(1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (Valid_out !== 1'b0 || Count !== 3'd0 || Data_out !== 8'h00) begin errors++; $display("FAIL post_reset_pop got V=%b C=%0d D=%h exp V=0 C=0 D=00", Valid_out, Count, Data_out); end
`ifdef WORD_QUEUE_ERROR_FLAGS_EN
    checks++;
    if (Underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got U=%b exp U=1", Underflow); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fifo();
    test_full();
    test_wrap();
    test_full_push_pop();
    test_empty_push_pop();
    test_enable_and_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
